// File: rtl/raw10_pkg.sv
// Shared definitions for the RAW10 byte-pair encoder.
//   state_e          : next-word-to-load FSM states W0..W4
//   InDataWidth      : pixel-group width (4 lanes of 16 bits)
//   OutDataWidth     : output byte-pair width
//   PixWidth         : significant bits per pixel lane
//   raw10_lsb_byte() : packs the 2 LSBs of the four pixels, first pixel lowest
//   raw10_pix_msb()  : returns pixel[9:2] of one lane
package raw10_pkg;

  localparam int unsigned InDataWidth  = 64;
  localparam int unsigned OutDataWidth = 16;
  localparam int unsigned PixWidth     = 10;

  typedef enum logic [2:0] {W0, W1, W2, W3, W4} state_e;

  function automatic logic [7:0] raw10_lsb_byte(input logic [InDataWidth-1:0] group);
    return {group[49:48], group[33:32], group[17:16], group[1:0]};
  endfunction

  // lane is 0-based: lane 0 holds the first pixel of the group
  function automatic logic [7:0] raw10_pix_msb(input logic [InDataWidth-1:0] group,
                                               input int unsigned lane);
    return group[16*lane+2 +: 8];
  endfunction

endpackage

// File: rtl/raw10_encoder.sv
// RAW10 encoder: turns pairs of 4-pixel groups (A, B) into five 16-bit words.
//   txbyteclkhs     : byte clock, all state on its rising edge
//   reset_n         : asynchronous active-low reset
//   frame_active    : low flushes the block at the next edge
//   data_in/in_valid/in_ready/last_packet_in : pixel-group input handshake
//   data_out/out_valid/out_ready/last_packet_out : byte-pair output handshake
// The state names the next word to load; the output stage is a single register
// that reloads whenever it is empty or being consumed.
module raw10_encoder
  import raw10_pkg::*;
#(
  parameter int unsigned IN_DATA_WIDTH  = 64,  // only 64 supported
  parameter int unsigned OUT_DATA_WIDTH = 16   // only 16 supported
) (
  input  logic                      txbyteclkhs,
  input  logic                      reset_n,
  input  logic                      frame_active,
  input  logic [IN_DATA_WIDTH-1:0]  data_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      last_packet_in,
  output logic [OUT_DATA_WIDTH-1:0] data_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      last_packet_out
);

  state_e                   state;
  logic [IN_DATA_WIDTH-1:0] grp_a;
  logic [IN_DATA_WIDTH-1:0] grp_b;
  logic                     last_a;
  logic                     last_b;
  logic                     load;

  assign load     = ~out_valid | out_ready;
  // reset_n term keeps in_ready low during reset independent of the output stage
  assign in_ready = reset_n & load & frame_active & ((state == W0) | (state == W2));

  always_ff @(posedge txbyteclkhs or negedge reset_n) begin
    if (!reset_n) begin
      state           <= W0;
      out_valid       <= 1'b0;
      data_out        <= '0;
      last_packet_out <= 1'b0;
      grp_a           <= '0;
      grp_b           <= '0;
      last_a          <= 1'b0;
      last_b          <= 1'b0;
    end else if (!frame_active) begin
      // Flush wins over any concurrent input handshake; a partial pair is dropped.
      state           <= W0;
      out_valid       <= 1'b0;
      data_out        <= '0;
      last_packet_out <= 1'b0;
      last_a          <= 1'b0;
      last_b          <= 1'b0;
    end else if (load) begin
      last_packet_out <= 1'b0;
      unique case (state)
        W0: begin
          if (in_valid) begin
            grp_a     <= data_in;
            last_a    <= last_packet_in;
            data_out  <= {raw10_pix_msb(data_in, 0), raw10_pix_msb(data_in, 1)};
            out_valid <= 1'b1;
            state     <= W1;
          end else begin
            out_valid <= 1'b0;
          end
        end
        W1: begin
          data_out  <= {raw10_pix_msb(grp_a, 2), raw10_pix_msb(grp_a, 3)};
          out_valid <= 1'b1;
          state     <= W2;
        end
        W2: begin
          if (in_valid) begin
            grp_b     <= data_in;
            last_b    <= last_packet_in;
            data_out  <= {raw10_lsb_byte(grp_a), raw10_pix_msb(data_in, 0)};
            out_valid <= 1'b1;
            state     <= W3;
          end else begin
            out_valid <= 1'b0;
          end
        end
        W3: begin
          data_out  <= {raw10_pix_msb(grp_b, 1), raw10_pix_msb(grp_b, 2)};
          out_valid <= 1'b1;
          state     <= W4;
        end
        W4: begin
          data_out        <= {raw10_pix_msb(grp_b, 3), raw10_lsb_byte(grp_b)};
          out_valid       <= 1'b1;
          last_packet_out <= last_a | last_b;
          state           <= W0;
        end
        default: begin
          out_valid <= 1'b0;
          state     <= W0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_raw10_encoder.sv
// Self-checking bench for raw10_encoder: scoreboard of expected words, directed
// cases for ordering, back-pressure, flush and reset, and a random run whose
// output is decoded back to pixels.
module tb_raw10_encoder;

  logic        txbyteclkhs = 1'b0;
  logic        reset_n     = 1'b0;
  logic        frame_active;
  logic [63:0] data_in;
  logic        in_valid;
  logic        in_ready;
  logic        last_packet_in;
  logic [15:0] data_out;
  logic        out_valid;
  logic        out_ready;
  logic        last_packet_out;

  raw10_encoder #(
    .IN_DATA_WIDTH (64),
    .OUT_DATA_WIDTH(16)
  ) dut (
    .txbyteclkhs    (txbyteclkhs),
    .reset_n        (reset_n),
    .frame_active   (frame_active),
    .data_in        (data_in),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .last_packet_in (last_packet_in),
    .data_out       (data_out),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .last_packet_out(last_packet_out)
  );

  always #5 txbyteclkhs = ~txbyteclkhs;

  int unsigned  n_tests = 0;
  int unsigned  n_fail  = 0;
  int unsigned  cyc     = 0;
  logic [16:0]  sb[$];       // {last, word}
  logic [16:0]  rx_log[$];
  int unsigned  rx_cyc[$];
  logic [79:0]  pix_q[$];    // {P8..P1}, 10 bits each
  logic [15:0]  dec_buf[$];
  logic [63:0]  m_a;
  logic         m_last_a;
  logic         have_a = 1'b0;
  logic         acc;
  logic         dec_en = 1'b0;
  int unsigned  pairs_done = 0;

  task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] msb(input logic [63:0] g, input int k);
    logic [15:0] lane;
    lane = g[16*k +: 16];
    return lane[9:2];
  endfunction

  function automatic logic [7:0] lsb(input logic [63:0] g);
    logic [7:0] l;
    for (int k = 0; k < 4; k++) begin
      logic [15:0] lane;
      lane = g[16*k +: 16];
      l[2*k +: 2] = lane[1:0];
    end
    return l;
  endfunction

  function automatic logic [79:0] pixels(input logic [63:0] a, input logic [63:0] b);
    logic [79:0] p;
    for (int k = 0; k < 4; k++) begin
      p[10*k +: 10]     = a[16*k +: 10];
      p[10*(k+4) +: 10] = b[16*k +: 10];
    end
    return p;
  endfunction

  // Inverse RAW10 packing of one five-word pair.
  function automatic logic [79:0] decode(input logic [15:0] w0, input logic [15:0] w1,
                                         input logic [15:0] w2, input logic [15:0] w3,
                                         input logic [15:0] w4);
    logic [7:0] la;
    logic [7:0] lb;
    la = w2[15:8];
    lb = w4[7:0];
    return {{w4[15:8], lb[7:6]}, {w3[7:0], lb[5:4]}, {w3[15:8], lb[3:2]}, {w2[7:0], lb[1:0]},
            {w1[7:0], la[7:6]}, {w1[15:8], la[5:4]}, {w0[7:0], la[3:2]}, {w0[15:8], la[1:0]}};
  endfunction

  // Called with inputs settled, before the next rising edge.
  task automatic observe();
    logic [16:0] got;
    logic [79:0] exp_pix;
    if (out_valid && out_ready) begin
      got = {last_packet_out, data_out};
      rx_log.push_back(got);
      rx_cyc.push_back(cyc);
      if (sb.size() == 0) check_eq("sb_underflow", {63'd0, got}, 80'h1_0000_0000_0000_0000);
      else check_eq("word", {63'd0, got}, {63'd0, sb.pop_front()});
      if (dec_en) begin
        dec_buf.push_back(data_out);
        if (dec_buf.size() == 5) begin
          exp_pix = (pix_q.size() != 0) ? pix_q.pop_front() : 80'hx;
          check_eq("decode", decode(dec_buf[0], dec_buf[1], dec_buf[2], dec_buf[3], dec_buf[4]),
                   exp_pix);
          dec_buf.delete();
        end
      end
    end
    acc = in_valid && in_ready;
    if (!frame_active) begin
      sb.delete();
      have_a = 1'b0;
    end else if (acc) begin
      if (!have_a) begin
        sb.push_back({1'b0, msb(data_in, 0), msb(data_in, 1)});
        sb.push_back({1'b0, msb(data_in, 2), msb(data_in, 3)});
        m_a      = data_in;
        m_last_a = last_packet_in;
        have_a   = 1'b1;
      end else begin
        sb.push_back({1'b0, lsb(m_a), msb(data_in, 0)});
        sb.push_back({1'b0, msb(data_in, 1), msb(data_in, 2)});
        sb.push_back({m_last_a | last_packet_in, msb(data_in, 3), lsb(data_in)});
        pix_q.push_back(pixels(m_a, data_in));
        pairs_done++;
        have_a = 1'b0;
      end
    end
  endtask

  task automatic step(input logic fa, input logic iv, input logic [63:0] d, input logic li,
                      input logic ordy);
    frame_active   = fa;
    in_valid       = iv;
    data_in        = d;
    last_packet_in = li;
    out_ready      = ordy;
    #1;
    observe();
    @(negedge txbyteclkhs);
    cyc++;
  endtask

  task automatic send_group(input logic [63:0] d, input logic li);
    int n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      step(1'b1, 1'b1, d, li, 1'b1);
      n++;
    end
    if (!acc) check_eq("send_timeout", 80'd0, 80'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      step(1'b1, 1'b0, 64'd0, 1'b0, 1'b1);
      n++;
    end
    check_eq("drain_empty", 80'(sb.size()), 80'd0);
  endtask

  localparam logic [63:0] GA = 64'h0004_0003_0002_0001;
  localparam logic [63:0] GB = 64'h03FF_03FE_03FD_03FC;
  logic [16:0] exp_pair[5];

  initial begin
    frame_active = 1'b1; in_valid = 1'b1; data_in = GA; last_packet_in = 1'b0;
    out_ready = 1'b1;
    exp_pair[0] = 17'h0_0000; exp_pair[1] = 17'h0_0001; exp_pair[2] = 17'h0_39FF;
    exp_pair[3] = 17'h0_FFFF; exp_pair[4] = 17'h0_FFE4;

    // Reset state
    #12;
    check_eq("rst_out_valid", {79'd0, out_valid}, 80'd0);
    check_eq("rst_data_out", {64'd0, data_out}, 80'd0);
    check_eq("rst_last", {79'd0, last_packet_out}, 80'd0);
    check_eq("rst_in_ready", {79'd0, in_ready}, 80'd0);
    @(negedge txbyteclkhs);
    reset_n = 1'b1;

    // Basic pair, no bubbles, last flag clear
    rx_log.delete(); rx_cyc.delete();
    send_group(GA, 1'b0);
    send_group(GB, 1'b0);
    drain();
    check_eq("t1_count", 80'(rx_log.size()), 80'd5);
    for (int i = 0; i < 5 && i < rx_log.size(); i++)
      check_eq("t1_word", {63'd0, rx_log[i]}, {63'd0, exp_pair[i]});
    for (int i = 0; i + 1 < rx_cyc.size(); i++)
      check_eq("t1_no_bubble", 80'(rx_cyc[i+1] - rx_cyc[i]), 80'd1);

    // last on B only marks the final word
    rx_log.delete();
    send_group(GA, 1'b0);
    send_group(GB, 1'b1);
    drain();
    exp_pair[4] = 17'h1_FFE4;
    check_eq("t2_count", 80'(rx_log.size()), 80'd5);
    for (int i = 0; i < 5 && i < rx_log.size(); i++)
      check_eq("t2_word", {63'd0, rx_log[i]}, {63'd0, exp_pair[i]});
    exp_pair[4] = 17'h0_FFE4;

    // Back-pressure while W1 word is presented
    rx_log.delete();
    send_group(GA, 1'b0);
    step(1'b1, 1'b0, 64'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, GB, 1'b0, 1'b0);
      check_eq("t3_hold_data", {64'd0, data_out}, 80'h0001);
      check_eq("t3_hold_valid", {79'd0, out_valid}, 80'd1);
      check_eq("t3_in_ready", {79'd0, in_ready}, 80'd0);
    end
    send_group(GB, 1'b0);
    drain();
    check_eq("t3_count", 80'(rx_log.size()), 80'd5);
    for (int i = 0; i < 5 && i < rx_log.size(); i++)
      check_eq("t3_word", {63'd0, rx_log[i]}, {63'd0, exp_pair[i]});

    // Flush after W1 output, then a fresh pair
    rx_log.delete();
    send_group(GA, 1'b0);
    step(1'b1, 1'b0, 64'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, GB, 1'b0, 1'b1);
    check_eq("t4_flush_valid", {79'd0, out_valid}, 80'd0);
    check_eq("t4_flush_data", {64'd0, data_out}, 80'd0);
    check_eq("t4_flush_last", {79'd0, last_packet_out}, 80'd0);
    frame_active = 1'b0; in_valid = 1'b1; #1;
    check_eq("t4_ready_inactive", {79'd0, in_ready}, 80'd0);
    send_group(64'h0123_0234_0345_0056, 1'b0);
    send_group(64'h03C3_0111_0222_0333, 1'b1);
    drain();
    check_eq("t4_count", 80'(rx_log.size()), 80'd7);
    if (rx_log.size() > 2) check_eq("t4_restart_w0", {63'd0, rx_log[2]}, 80'h0_15D1);

    // Asynchronous reset while W3 is the next word to load
    rx_log.delete();
    send_group(GA, 1'b0);
    send_group(GB, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", {79'd0, out_valid}, 80'd0);
    check_eq("t5_rst_data", {64'd0, data_out}, 80'd0);
    check_eq("t5_rst_in_ready", {79'd0, in_ready}, 80'd0);
    sb.delete(); have_a = 1'b0;
    @(negedge txbyteclkhs);
    reset_n = 1'b1;
    send_group(64'h0000_0000_0300_00C0, 1'b0);
    send_group(GB, 1'b0);
    drain();
    if (rx_log.size() > 2) check_eq("t5_first_is_a", {63'd0, rx_log[2]}, 80'h0_30C0);
    else check_eq("t5_count", 80'(rx_log.size()), 80'd7);

    // Random handshakes over 1000 pairs, decoded back to pixels
    dec_en = 1'b1; dec_buf.delete(); pix_q.delete(); pairs_done = 0;
    begin
      int guard = 0;
      while (pairs_done < 1000 && guard < 40000) begin
        step(1'b1, $urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 7) == 0,
             $urandom_range(0, 3) != 0);
        guard++;
      end
      check_eq("rand_pairs", 80'(pairs_done), 80'd1000);
    end
    drain();
    check_eq("rand_decoded_all", 80'(pix_q.size()), 80'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
